// File: rtl/progmem_read_arbiter.sv
// progmem_read_arbiter
// Shares a single program-memory read port among NUM_REQUESTERS fetchers.
// Round-robin arbitration, one downstream read in flight at a time, all
// outputs registered. Requesters and memory use the same valid/address ->
// ready/data handshake.
//
// Optional feature: define PROGMEM_ARB_MERGE_EN to let every requester that
// is asking for the winner's address share the winner's downstream read.
module progmem_read_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQUESTERS-1:0]           req_read_valid,
    input  logic [NUM_REQUESTERS*ADDR_BITS-1:0] req_read_address,
    output logic [NUM_REQUESTERS-1:0]           req_read_ready,
    output logic [NUM_REQUESTERS*DATA_BITS-1:0] req_read_data,
    output logic                                mem_read_valid,
    output logic [ADDR_BITS-1:0]                mem_read_address,
    input  logic                                mem_read_ready,
    input  logic [DATA_BITS-1:0]                mem_read_data
);

    localparam int IDX_BITS = $clog2(NUM_REQUESTERS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESPOND
    } state_t;

    state_t                    state;
    logic [NUM_REQUESTERS-1:0] grant;
    logic [IDX_BITS-1:0]       last_grant;

    logic                      any_valid;
    logic [IDX_BITS-1:0]       winner;
    logic [IDX_BITS-1:0]       cand;
    int                        cand_int;
    logic [ADDR_BITS-1:0]      winner_address;
    logic [NUM_REQUESTERS-1:0] next_grant;
    logic [NUM_REQUESTERS-1:0] still_held;

    // Round-robin winner search starting just after the last granted requester.
    // Walking from the farthest candidate back to the nearest leaves the
    // highest-priority valid requester as the final assignment.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        cand      = '0;
        cand_int  = 0;
        for (int k = NUM_REQUESTERS; k >= 1; k--) begin
            cand_int = (int'(last_grant) + k) % NUM_REQUESTERS;
            cand     = IDX_BITS'(cand_int);
            if (req_read_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    // Grant mask for the next transaction: the winner, plus address-matching
    // requesters when merging is enabled.
    always_comb begin
        winner_address     = req_read_address[winner*ADDR_BITS +: ADDR_BITS];
        next_grant         = '0;
        next_grant[winner] = 1'b1;
`ifdef PROGMEM_ARB_MERGE_EN
        for (int j = 0; j < NUM_REQUESTERS; j++) begin
            if (req_read_valid[j] &&
                (req_read_address[j*ADDR_BITS +: ADDR_BITS] == winner_address)) begin
                next_grant[j] = 1'b1;
            end
        end
`endif
        still_held = req_read_ready & req_read_valid;
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            grant            <= '0;
            last_grant       <= IDX_BITS'(NUM_REQUESTERS - 1);
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            req_read_ready   <= '0;
            req_read_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant            <= next_grant;
                        last_grant       <= winner;
                        mem_read_address <= winner_address;
                        mem_read_valid   <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Address and valid stay put until the memory answers.
                    if (mem_read_ready) begin
                        mem_read_valid <= 1'b0;
                        for (int i = 0; i < NUM_REQUESTERS; i++) begin
                            if (grant[i]) begin
                                req_read_data[i*DATA_BITS +: DATA_BITS] <= mem_read_data;
                            end
                        end
                        req_read_ready <= grant;
                        state          <= RESPOND;
                    end
                end
                RESPOND: begin
                    // Each ready drops once its requester lets go of valid;
                    // a requester that already dropped valid gets a one-cycle ack.
                    req_read_ready <= still_held;
                    if (still_held == '0) begin
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_progmem_read_arbiter.sv
// Testbench for progmem_read_arbiter: behavioural memory with programmable
// latency, per-requester read tasks and a response scoreboard.
module tb_progmem_read_arbiter;

    localparam int NREQ  = 2;
    localparam int ABITS = 8;
    localparam int DBITS = 16;

    logic                    clk;
    logic                    reset;
    logic [NREQ-1:0]         req_read_valid;
    logic [NREQ*ABITS-1:0]   req_read_address;
    logic [NREQ-1:0]         req_read_ready;
    logic [NREQ*DBITS-1:0]   req_read_data;
    logic                    mem_read_valid;
    logic [ABITS-1:0]        mem_read_address;
    logic                    mem_read_ready;
    logic [DBITS-1:0]        mem_read_data;

    progmem_read_arbiter #(
        .NUM_REQUESTERS(NREQ),
        .ADDR_BITS     (ABITS),
        .DATA_BITS     (DBITS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_read_valid   (req_read_valid),
        .req_read_address (req_read_address),
        .req_read_ready   (req_read_ready),
        .req_read_data    (req_read_data),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data)
    );

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  addr_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_mem    = 0;
    int mem_lat  = 1;
    bit inject   = 0;
    bit mon_en   = 0;
    int lat0, lat1, n0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] memf(input logic [7:0] a);
        if (a == 8'h10) return 16'hABCD;
        if (a == 8'h20) return 16'h1234;
        return {~a, a};
    endfunction

    task automatic expect_read(input int r, input logic [7:0] a);
        exp_t e;
        e.idx  = r;
        e.data = memf(a);
        addr_q.push_back(a);
        sb.push_back(e);
    endtask

    // Memory model: answers mem_lat cycles after it first sees a request.
    initial begin
        bit         pending;
        int         wait_left;
        logic [7:0] txn_addr;
        pending        = 0;
        wait_left      = 0;
        txn_addr       = '0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_read_ready) begin
                mem_read_ready = 1'b0;
                pending        = 0;
            end else if (inject) begin
                mem_read_ready = 1'b1;
                mem_read_data  = 16'hDEAD;
                inject         = 0;
            end else if (mem_read_valid) begin
                if (!pending) begin
                    pending   = 1;
                    wait_left = mem_lat;
                    txn_addr  = mem_read_address;
                    n_mem++;
                    chk("mem_expected", 32'(addr_q.size() != 0), 1);
                    if (addr_q.size() != 0) chk("mem_addr", mem_read_address, addr_q.pop_front());
                end else begin
                    chk("mem_addr_hold", mem_read_address, txn_addr);
                end
                if (wait_left == 0) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = memf(txn_addr);
                end else begin
                    wait_left--;
                end
            end else begin
                pending = 0;
            end
        end
    end

    // Response monitor: each rising ready must match the scoreboard head;
    // other data slices must not move.
    initial begin
        logic [NREQ-1:0]       prev_rdy;
        logic [NREQ*DBITS-1:0] prev_data;
        exp_t                  e;
        prev_rdy  = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_read_ready[i] && !prev_rdy[i]) begin
                        chk("rsp_expected", 32'(sb.size() != 0), 1);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            chk("rsp_idx", i, e.idx);
                            chk("rsp_data", req_read_data[i*DBITS +: DBITS], e.data);
                        end
                    end else if (req_read_data[i*DBITS +: DBITS] != prev_data[i*DBITS +: DBITS]) begin
                        chk("data_hold", req_read_data[i*DBITS +: DBITS], prev_data[i*DBITS +: DBITS]);
                    end
                end
            end
            prev_rdy  = req_read_ready;
            prev_data = req_read_data;
        end
    end

    task automatic do_reset();
        mon_en           = 0;
        reset            = 1'b1;
        req_read_valid   = '0;
        req_read_address = '0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1;
    endtask

    // One requester transaction; called at a negedge.
    task automatic do_read(input int r, input logic [7:0] a, input int hold, output int lat);
        int cnt = 0;
        req_read_valid[r]                  = 1'b1;
        req_read_address[r*ABITS +: ABITS] = a;
        while (!req_read_ready[r] && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        lat = cnt;
        chk("rd_ack", req_read_ready[r], 1);
        repeat (hold) begin
            @(negedge clk);
            chk("ready_hold", req_read_ready[r], 1);
            chk("respond_no_issue", mem_read_valid, 0);
        end
        req_read_valid[r] = 1'b0;
        @(negedge clk);
        chk("ready_clear", req_read_ready[r], 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        req_read_valid   = '0;
        req_read_address = '0;
        @(negedge clk);
        do_reset();
        chk("rst_mem_valid", mem_read_valid, 0);
        chk("rst_mem_addr", mem_read_address, 0);
        chk("rst_ready", req_read_ready, 0);
        chk("rst_data", req_read_data, 0);

        // Single request with a 1-cycle memory
        mem_lat = 1;
        expect_read(0, 8'h10);
        do_read(0, 8'h10, 0, lat0);
        chk("single_latency", lat0, 3);
        chk("single_req1_ready", req_read_ready[1], 0);
        chk("single_req1_data", req_read_data[DBITS +: DBITS], 0);

        // Contention from reset, then held requests alternate 0,1,0,1
        do_reset();
        expect_read(0, 8'h03);
        expect_read(1, 8'h07);
        fork
            do_read(0, 8'h03, 0, lat0);
            do_read(1, 8'h07, 0, lat1);
        join
        do_reset();
        expect_read(0, 8'h03);
        expect_read(1, 8'h07);
        expect_read(0, 8'h13);
        expect_read(1, 8'h17);
        fork
            begin
                int l;
                for (int i = 0; i < 2; i++) do_read(0, 8'(8'h03 + 16 * i), 0, l);
            end
            begin
                int l;
                for (int i = 0; i < 2; i++) do_read(1, 8'(8'h07 + 16 * i), 0, l);
            end
        join

        // Slow memory
        do_reset();
        mem_lat = 5;
        expect_read(1, 8'h44);
        do_read(1, 8'h44, 0, lat1);
        chk("slow_latency", lat1, 7);
        mem_lat = 1;

        // Requester 0 holds valid in RESPOND; requester 1 must wait
        do_reset();
        expect_read(0, 8'h30);
        expect_read(1, 8'h31);
        fork
            do_read(0, 8'h30, 3, lat0);
            begin
                @(negedge clk);
                do_read(1, 8'h31, 0, lat1);
            end
        join

        // Reset during ISSUE
        do_reset();
        expect_read(0, 8'h40);
        do_read(0, 8'h40, 0, lat0);
        mem_lat = 20;
        addr_q.push_back(8'h41);
        req_read_valid[0]          = 1'b1;
        req_read_address[0 +: 8]   = 8'h41;
        lat0 = 0;
        while (!mem_read_valid && lat0 < 10) begin
            @(negedge clk);
            lat0++;
        end
        chk("issue_seen", mem_read_valid, 1);
        mon_en         = 0;
        reset          = 1'b1;
        req_read_valid = '0;
        @(negedge clk);
        chk("midrst_mem_valid", mem_read_valid, 0);
        chk("midrst_mem_addr", mem_read_address, 0);
        chk("midrst_ready", req_read_ready, 0);
        chk("midrst_data", req_read_data, 0);
        reset  = 1'b0;
        inject = 1;
        repeat (3) @(negedge clk);
        chk("stray_ready_mem_valid", mem_read_valid, 0);
        chk("stray_ready_ready", req_read_ready, 0);
        chk("stray_ready_data", req_read_data, 0);
        mem_lat = 1;
        mon_en  = 1;
        expect_read(0, 8'h50);
        expect_read(1, 8'h51);
        fork
            do_read(0, 8'h50, 0, lat0);
            do_read(1, 8'h51, 0, lat1);
        join

        // Identical addresses: merged or fetched twice
        do_reset();
        n0 = n_mem;
`ifdef PROGMEM_ARB_MERGE_EN
        begin
            exp_t e;
            addr_q.push_back(8'h20);
            e.data = 16'h1234;
            e.idx  = 0;
            sb.push_back(e);
            e.idx  = 1;
            sb.push_back(e);
        end
`else
        expect_read(0, 8'h20);
        expect_read(1, 8'h20);
`endif
        fork
            do_read(0, 8'h20, 0, lat0);
            do_read(1, 8'h20, 0, lat1);
        join
`ifdef PROGMEM_ARB_MERGE_EN
        chk("merge_txns", n_mem - n0, 1);
        chk("merge_same_edge", lat1, lat0);
`else
        chk("nomerge_txns", n_mem - n0, 2);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("addr_q_drained", addr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
